// File: rtl/b2_demux_1_4_stream_if.sv
// Stream bundle for the 1:4 demux: one producer-side input, four consumer channels.
// Debug select (cur_sel) travels with the bundle so LEDs can tap it.
interface b2_demux_1_4_stream_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         sel;
  logic               auto;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [1:0]         cur_sel;

  modport master (
    output in_data, in_valid, sel, auto, out_ready,
    input  in_ready, out_data, out_valid, cur_sel
  );

  modport slave (
    input  in_data, in_valid, sel, auto, out_ready,
    output in_ready, out_data, out_valid, cur_sel
  );
endinterface

// File: rtl/b2_demux_1_4_stream.sv
// Registered 1:4 stream demux; destination is external sel or an internal
// round-robin pointer that only advances on accepted words.

// One output holding register: load wins over drain so a same-cycle
// drain+load keeps valid high with the new word.
module b2_demux_lane #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             vld
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      vld  <= 1'b0;
    end else if (load) begin
      dout <= din;
      vld  <= 1'b1;
    end else if (drain) begin
      vld  <= 1'b0;
    end
  end
endmodule

module b2_demux_1_4_stream #(
  parameter int WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  b2_demux_1_4_stream_if.slave  bus
);
  localparam int NUM_LANES = 4;

  logic [1:0]                       scan_ptr;
  logic [1:0]                       dst;
  logic                             accept;
  logic [NUM_LANES-1:0]             load;
  logic [NUM_LANES-1:0]             drain;
  logic [NUM_LANES-1:0]             vld;
  logic [NUM_LANES-1:0][WIDTH-1:0]  slot;
  logic [WIDTH-1:0]                 din;

  assign din          = bus.in_data;
  assign dst          = bus.auto ? scan_ptr : bus.sel;
  assign bus.cur_sel  = dst;
  // A slot being drained this cycle is free for a new word on the same edge.
  assign bus.in_ready = !vld[dst] || bus.out_ready[dst];
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = vld & bus.out_ready;

  always_comb begin
    load = '0;
    if (accept) load[dst] = 1'b1;
  end

  b2_demux_lane #(.WIDTH(WIDTH)) u_lane [NUM_LANES-1:0] (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .drain (drain),
    .din   (din),
    .dout  (slot),
    .vld   (vld)
  );

  assign bus.out_data  = slot;
  assign bus.out_valid = vld;

  // Pointer is frozen outside auto mode so re-entry resumes where it left off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  scan_ptr <= 2'd0;
    else if (bus.auto && accept) scan_ptr <= scan_ptr + 2'd1;
  end
endmodule

// File: tb/tb_b2_demux_1_4_stream.sv
// Directed bench for the 1:4 stream demux: reset, manual routing, auto scan,
// backpressure, concurrent drain and mode switching.
module tb_b2_demux_1_4_stream;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  b2_demux_1_4_stream_if #(.WIDTH(2)) bus();

  b2_demux_1_4_stream #(.WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] d, input logic a,
                       input logic [1:0] s, input logic [3:0] ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.auto      = a;
    bus.sel       = s;
    bus.out_ready = ordy;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 2'd1, 4'b0000);
    chk("rst_ovalid", 32'(bus.out_valid), 32'h0);
    chk("rst_odata",  32'(bus.out_data),  32'h0);
    chk("rst_irdy",   32'(bus.in_ready),  32'h1);
    chk("rst_cursel_manual", 32'(bus.cur_sel), 32'd1);
    step();
    rst = 1'b0;

    // manual routing and stall on a full channel
    drive(1'b1, 2'b11, 1'b0, 2'd2, 4'b0000);
    chk("man_irdy0",  32'(bus.in_ready), 32'h1);
    chk("man_cursel", 32'(bus.cur_sel),  32'd2);
    step();
    drive(1'b1, 2'b01, 1'b0, 2'd2, 4'b0000);
    chk("man_ovalid1", 32'(bus.out_valid),     32'b0100);
    chk("man_data1",   32'(bus.out_data[5:4]), 32'h3);
    chk("man_stall",   32'(bus.in_ready),      32'h0);
    step();
    chk("man_hold_v",  32'(bus.out_valid),     32'b0100);
    chk("man_hold_d",  32'(bus.out_data[5:4]), 32'h3);
    drive(1'b1, 2'b01, 1'b0, 2'd2, 4'b0100);
    chk("man_release", 32'(bus.in_ready), 32'h1);
    step();
    drive(1'b0, 2'b00, 1'b0, 2'd2, 4'b0000);
    chk("man_ovalid2", 32'(bus.out_valid),     32'b0100);
    chk("man_data2",   32'(bus.out_data[5:4]), 32'h1);

    // drain everything
    drive(1'b0, 2'b00, 1'b0, 2'd0, 4'b1111);
    step();
    chk("drain_all", 32'(bus.out_valid), 32'h0);

    // auto scan with wrap
    drive(1'b1, 2'b01, 1'b1, 2'd3, 4'b1111);
    chk("auto_cur0", 32'(bus.cur_sel), 32'd0);
    step();
    chk("auto_v0", 32'(bus.out_valid), 32'b0001);
    chk("auto_d0", 32'(bus.out_data[1:0]), 32'h1);
    chk("auto_cur1", 32'(bus.cur_sel), 32'd1);
    drive(1'b1, 2'b10, 1'b1, 2'd3, 4'b1111);
    step();
    chk("auto_v1", 32'(bus.out_valid), 32'b0010);
    chk("auto_d1", 32'(bus.out_data[3:2]), 32'h2);
    chk("auto_cur2", 32'(bus.cur_sel), 32'd2);
    drive(1'b1, 2'b11, 1'b1, 2'd3, 4'b1111);
    step();
    chk("auto_v2", 32'(bus.out_valid), 32'b0100);
    chk("auto_d2", 32'(bus.out_data[5:4]), 32'h3);
    chk("auto_cur3", 32'(bus.cur_sel), 32'd3);
    drive(1'b1, 2'b00, 1'b1, 2'd3, 4'b1111);
    step();
    chk("auto_v3", 32'(bus.out_valid), 32'b1000);
    chk("auto_d3", 32'(bus.out_data[7:6]), 32'h0);
    chk("auto_wrap", 32'(bus.cur_sel), 32'd0);
    drive(1'b1, 2'b01, 1'b1, 2'd3, 4'b1111);
    step();
    chk("auto_v4", 32'(bus.out_valid), 32'b0001);
    chk("auto_d4", 32'(bus.out_data[1:0]), 32'h1);
    chk("auto_cur_after", 32'(bus.cur_sel), 32'd1);

    // auto backpressure: fill ch1 manually, pointer sits at 1
    drive(1'b1, 2'b10, 1'b0, 2'd1, 4'b1101);
    step();
    chk("bp_fill", 32'(bus.out_valid), 32'b0010);
    drive(1'b1, 2'b11, 1'b1, 2'd0, 4'b1101);
    chk("bp_cur", 32'(bus.cur_sel), 32'd1);
    chk("bp_stall", 32'(bus.in_ready), 32'h0);
    step();
    chk("bp_ptr_hold", 32'(bus.cur_sel), 32'd1);
    chk("bp_data_hold", 32'(bus.out_data[3:2]), 32'h2);
    drive(1'b1, 2'b11, 1'b1, 2'd0, 4'b1111);
    chk("bp_release", 32'(bus.in_ready), 32'h1);
    step();
    chk("bp_v", 32'(bus.out_valid), 32'b0010);
    chk("bp_d", 32'(bus.out_data[3:2]), 32'h3);
    chk("bp_ptr_adv", 32'(bus.cur_sel), 32'd2);

    // concurrency: ch3 drains while ch0 loads
    drive(1'b1, 2'b01, 1'b0, 2'd3, 4'b0111);
    step();
    chk("cc_setup", 32'(bus.out_valid), 32'b1000);
    drive(1'b1, 2'b10, 1'b0, 2'd0, 4'b1000);
    step();
    chk("cc_v", 32'(bus.out_valid), 32'b0001);
    chk("cc_d", 32'(bus.out_data[1:0]), 32'h2);

    // mode switch: pointer frozen at 2 while manual
    drive(1'b0, 2'b00, 1'b1, 2'd0, 4'b1111);
    chk("ms_cur_auto", 32'(bus.cur_sel), 32'd2);
    drive(1'b1, 2'b11, 1'b0, 2'd0, 4'b1111);
    step();
    chk("ms_man_v", 32'(bus.out_valid), 32'b0001);
    chk("ms_man_d", 32'(bus.out_data[1:0]), 32'h3);
    drive(1'b1, 2'b01, 1'b1, 2'd0, 4'b1111);
    chk("ms_resume", 32'(bus.cur_sel), 32'd2);
    step();
    chk("ms_auto_v", 32'(bus.out_valid), 32'b0100);
    chk("ms_auto_d", 32'(bus.out_data[5:4]), 32'h1);
    chk("ms_ptr3", 32'(bus.cur_sel), 32'd3);

    // async reset mid-run with out_valid=1010
    drive(1'b1, 2'b10, 1'b0, 2'd1, 4'b0100);
    step();
    drive(1'b1, 2'b01, 1'b0, 2'd3, 4'b0000);
    step();
    chk("mr_pre", 32'(bus.out_valid), 32'b1010);
    drive(1'b1, 2'b11, 1'b1, 2'd2, 4'b0000);
    #1 rst = 1'b1;
    #1;
    chk("mr_ovalid", 32'(bus.out_valid), 32'h0);
    chk("mr_odata",  32'(bus.out_data),  32'h0);
    chk("mr_cursel", 32'(bus.cur_sel),   32'd0);
    chk("mr_irdy",   32'(bus.in_ready),  32'h1);
    step();
    chk("mr_no_accept", 32'(bus.out_valid), 32'h0);
    rst = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 2'd0, 4'b0000);
    step();
    chk("post_rst_idle", 32'(bus.out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
